// File: rtl/cache_arbiter_pkg.sv
// arbiter_types: shared type definitions for the cache arbiter.
//   state_e : arbiter FSM states (IDLE, GNT_I, GNT_D, DONE)
//   owner_e : which cache currently owns the memory port (OWN_I, OWN_D)
package arbiter_types;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

endpackage

// File: rtl/cache_arbiter_perf_counter.sv
// perf_counter: free-running event counter, wraps modulo 2^CNT_W.
//   clk   : clock
//   rst   : asynchronous active-low reset, clears the count
//   inc   : add one to the count on the next rising edge
//   count : current count value (registered)
module perf_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: natural binary overflow provides the wrap to zero.
    always_comb begin
        count_d = count_q;
        if (inc) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/cache_arbiter.sv
// cache_arbiter: shares one memory port between an instruction cache and a
// data cache. Data requests win over instruction requests. Each grant runs
// until m_resp, then a single DONE cycle lets the requester drop its level
// request before the next arbitration.
//   clk, rst                : clock, asynchronous active-low reset
//   i_read/i_addr           : instruction line-fill request
//   i_rdata/i_resp          : returned line and completion pulse
//   d_read/d_write/d_addr/d_wdata : data fill / writeback request
//   d_rdata/d_resp          : returned line and completion pulse
//   m_read/m_write/m_addr/m_wdata : shared memory command (registered)
//   m_rdata/m_resp          : shared memory return
//   cnt_inst/cnt_data/cnt_conflict : grant and contention counters
module cache_arbiter
    import arbiter_types::*;
#(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              m_read,
    output logic              m_write,
    output logic [ADDR_W-1:0] m_addr,
    output logic [LINE_W-1:0] m_wdata,
    input  logic [LINE_W-1:0] m_rdata,
    input  logic              m_resp,
    output logic [CNT_W-1:0]  cnt_inst,
    output logic [CNT_W-1:0]  cnt_data,
    output logic [CNT_W-1:0]  cnt_conflict
);

    state_e            state_q,   state_d;
    owner_e            owner_q,   owner_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [LINE_W-1:0] wdata_q,   wdata_d;
    logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
    logic [LINE_W-1:0] d_rdata_q, d_rdata_d;
    logic              m_read_q,  m_read_d;
    logic              m_write_q, m_write_d;

    logic d_req_s;
    logic idle_s;
    logic inc_inst_s;
    logic inc_data_s;
    logic inc_conf_s;

    assign d_req_s    = d_read | d_write;
    assign idle_s     = (state_q == IDLE);
    assign inc_data_s = idle_s & d_req_s;
    assign inc_inst_s = idle_s & ~d_req_s & i_read;
    assign inc_conf_s = idle_s & d_req_s & i_read;

    // Next-state and owner-register logic; all m_* outputs come from flops.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        m_read_d  = m_read_q;
        m_write_d = m_write_q;
        case (state_q)
            IDLE: begin
                if (d_req_s) begin
                    // Read+write together: the writeback goes first.
                    state_d   = GNT_D;
                    owner_d   = OWN_D;
                    addr_d    = d_addr;
                    wdata_d   = d_wdata;
                    m_write_d = d_write;
                    m_read_d  = ~d_write;
                end else if (i_read) begin
                    state_d   = GNT_I;
                    owner_d   = OWN_I;
                    addr_d    = i_addr;
                    wdata_d   = '0;
                    m_read_d  = 1'b1;
                    m_write_d = 1'b0;
                end else begin
                    state_d   = IDLE;
                    m_read_d  = 1'b0;
                    m_write_d = 1'b0;
                end
            end
            GNT_I, GNT_D: begin
                if (m_resp) begin
                    state_d   = DONE;
                    m_read_d  = 1'b0;
                    m_write_d = 1'b0;
                    if (owner_q == OWN_I) begin
                        i_rdata_d = m_rdata;
                    end else begin
                        d_rdata_d = m_rdata;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            DONE: begin
                state_d   = IDLE;
                m_read_d  = 1'b0;
                m_write_d = 1'b0;
            end
            default: begin
                state_d   = IDLE;
                m_read_d  = 1'b0;
                m_write_d = 1'b0;
            end
        endcase
    end

    // FSM, owner and return-line registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            owner_q   <= OWN_I;
            addr_q    <= '0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            m_read_q  <= 1'b0;
            m_write_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            m_read_q  <= m_read_d;
            m_write_q <= m_write_d;
        end
    end

    assign m_read  = m_read_q;
    assign m_write = m_write_q;
    assign m_addr  = addr_q;
    assign m_wdata = wdata_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;

    // Completion pulses follow m_resp in the same cycle, only for the owner.
    assign i_resp = m_resp & (state_q == GNT_I);
    assign d_resp = m_resp & (state_q == GNT_D);

    perf_counter #(.CNT_W(CNT_W)) u_cnt_inst (
        .clk   (clk),
        .rst   (rst),
        .inc   (inc_inst_s),
        .count (cnt_inst)
    );

    perf_counter #(.CNT_W(CNT_W)) u_cnt_data (
        .clk   (clk),
        .rst   (rst),
        .inc   (inc_data_s),
        .count (cnt_data)
    );

    perf_counter #(.CNT_W(CNT_W)) u_cnt_conflict (
        .clk   (clk),
        .rst   (rst),
        .inc   (inc_conf_s),
        .count (cnt_conflict)
    );

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 Parameter LINE_W, 256, cache line width in bits.
REQ-002 Parameter ADDR_W, 32, line address width in bits.
REQ-003 Parameter CNT_W, 16, width of each performance counter.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous assertion, active-low (0 = reset).
REQ-006 i_read  input  1  instruction cache line-fill request, level-held until i_resp.
REQ-007 i_addr  input  ADDR_W  instruction request line address.
REQ-008 i_rdata  output  LINE_W  line returned to instruction cache.
REQ-009 i_resp  output  1  one-cycle completion pulse to instruction cache.
REQ-010 d_read / d_write  input  1 each  data cache fill / writeback request, level-held until d_resp.
REQ-011 d_addr  input  ADDR_W  data request line address.
REQ-012 d_wdata  input  LINE_W  data cache writeback line.
REQ-013 d_rdata  output  LINE_W  line returned to data cache.
REQ-014 d_resp  output  1  one-cycle completion pulse to data cache.
REQ-015 m_read / m_write  output  1 each  shared memory port commands, held until m_resp.
REQ-016 m_addr  output  ADDR_W  shared memory port address.
REQ-017 m_wdata  output  LINE_W  shared memory port write line.
REQ-018 m_rdata  input  LINE_W  shared memory port read line, valid with m_resp.
REQ-019 m_resp  input  1  shared memory port completion pulse.
REQ-020 cnt_inst, cnt_data, cnt_conflict  output  CNT_W each  grant and contention counters.

Function
REQ-021 States: IDLE, GNT_I, GNT_D, DONE; state register only.
REQ-022 IDLE: d_read or d_write asserted -> GNT_D; else i_read -> GNT_I; else remain IDLE.
REQ-023 Data requests have fixed priority over instruction requests (older pipeline stage).
REQ-024 Entering GNT_x latches requester address, command, and write line into owner registers; m_* driven only from these registers.
REQ-025 m_read/m_write asserted every cycle in GNT_x, deasserted in IDLE and DONE; never both high.
REQ-026 GNT_I drives m_read=1, m_write=0 regardless of other inputs.
REQ-027 GNT_D with both d_read and d_write high at grant latches write (writeback first).
REQ-028 In GNT_x, m_resp=1 -> capture m_rdata to owner's rdata register, pulse owner's resp for exactly that cycle (combinational from m_resp), go to DONE.
REQ-029 Non-owner resp stays 0 in all cycles; stray m_resp in IDLE or DONE ignored.
REQ-030 DONE lasts exactly one cycle, then IDLE; lets requester drop level request before re-arbitration.
REQ-031 Minimum latency: request seen in IDLE at cycle N -> m_read/m_write at N+1; back-to-back grants separated by one DONE cycle.
REQ-032 i_rdata/d_rdata hold last captured line until next capture by same owner.
REQ-033 Requests changing while granted do not affect the in-flight transaction.
REQ-034 cnt_inst/cnt_data increment by 1 on each entry to GNT_I/GNT_D.
REQ-035 cnt_conflict increments when IDLE sees both a data request and i_read in same cycle.
REQ-036 Counters wrap modulo 2^CNT_W (all-ones + 1 -> 0).

Reset
REQ-037 rst low forces immediately, without clock: state=IDLE, m_read=m_write=0, i_resp=d_resp=0, owner registers, rdata registers, and all counters = 0.
REQ-038 Reset mid-transaction abandons it; no resp issued for it after rst returns high.
REQ-039 First arbitration after reset release occurs on first rising edge with rst high.

Structure
REQ-040 State enum (IDLE, GNT_I, GNT_D, DONE) and owner enum (OWN_I, OWN_D) live in shared package arbiter_types.
REQ-041 Counters implemented as sub-module perf_counter (CNT_W, inc, wrapping), instantiated three times.
REQ-042 Single module otherwise; no memory, no multicycle combinational paths from m_rdata.

Verification
REQ-043 i_read alone, addr 0x0000_1000, m_resp 5 cycles after m_read -> m_addr 0x0000_1000, i_resp one cycle, i_rdata = m_rdata, cnt_inst=1.
REQ-044 i_read and d_read same cycle (0x100/0x200) -> data served first, then instruction after one DONE cycle, cnt_conflict=1, cnt_data=1, cnt_inst=1.
REQ-045 d_read and d_write both high, d_wdata 0xA5 pattern -> m_write=1, m_wdata=pattern, m_read=0.
REQ-046 rst low during GNT_D, before m_resp -> m_read=0 same cycle, state IDLE, no d_resp afterward.
REQ-047 Force cnt_inst to 0xFFFF, one instruction grant -> cnt_inst=0x0000.
REQ-048 m_resp pulsed in IDLE -> no i_resp/d_resp, rdata registers unchanged.
